// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, status-register
// bit positions and FSM state codes.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOT  = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_XOR  = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_ROR  = 4'd6,
        OP_ROL  = 4'd7,
        OP_INC  = 4'd8,
        OP_DEC  = 4'd9,
        OP_ADD  = 4'd10,
        OP_ADC  = 4'd11,
        OP_SUB  = 4'd12,
        OP_SBB  = 4'd13,
        OP_CMP  = 4'd14,
        OP_LDSR = 4'd15
    } op_e;

    localparam int FLAG_V = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ops with half/full-word masking and {V,S,Z,C} generation.
// Shift ops and LDSR pass the masked operand through; the caller handles them.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  op_e              op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    localparam int HW = WIDTH / 2;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] ar_w;
    logic [WIDTH-1:0] fsrc;
    logic [WIDTH:0]   ar;
    logic             is_add;
    logic             ci;
    logic             cy;
    logic             a_s;
    logic             o_s;
    logic             r_s;
    logic             ovf;
    logic             c_new;
    logic             v_new;

    always_comb begin
        mask   = mode ? {WIDTH{1'b1}} : {{HW{1'b0}}, {HW{1'b1}}};
        a_m    = a & mask;
        b_m    = b & mask;
        is_add = (op == OP_INC) || (op == OP_ADD) || (op == OP_ADC);
        opnd   = ((op == OP_INC) || (op == OP_DEC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_m;
        ci     = ((op == OP_ADC) || (op == OP_SBB)) ? c_in : 1'b0;
        if (is_add) begin
            ar = {1'b0, a_m} + {1'b0, opnd} + {{WIDTH{1'b0}}, ci};
        end else begin
            ar = {1'b0, a_m} - {1'b0, opnd} - {{WIDTH{1'b0}}, ci};
        end
        ar_w = ar[WIDTH-1:0] & mask;
        // In half-word mode the carry/borrow lands on bit HW of the masked sum.
        cy   = mode ? ar[WIDTH] : ar[HW];
        a_s  = mode ? a_m[WIDTH-1]  : a_m[HW-1];
        o_s  = mode ? opnd[WIDTH-1] : opnd[HW-1];
        r_s  = mode ? ar_w[WIDTH-1] : ar_w[HW-1];
        ovf  = is_add ? ((a_s == o_s) && (r_s != a_s)) : ((a_s != o_s) && (r_s != a_s));

        res   = a_m;
        c_new = c_in;
        v_new = 1'b0;
        case (op)
            OP_NOT: res = ~a & mask;
            OP_AND: res = a_m & b_m;
            OP_OR:  res = a_m | b_m;
            OP_XOR: res = a_m ^ b_m;
            OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                res   = ar_w;
                c_new = cy;
                v_new = ovf;
            end
            OP_CMP: begin
                c_new = cy;
                v_new = ovf;
            end
            default: ;
        endcase

        fsrc          = (op == OP_CMP) ? ar_w : res;
        flags         = '0;
        flags[FLAG_V] = v_new;
        flags[FLAG_S] = mode ? fsrc[WIDTH-1] : fsrc[HW-1];
        flags[FLAG_Z] = (fsrc == '0);
        flags[FLAG_C] = c_new;
        if (op == OP_LDSR) begin
            flags = a[3:0];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: 1 cycle to out_valid, n+1 for a shift/rotate by n.
// Holds out_data/sr while out_ready is low; accepts nothing until the result is taken.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       sr
);

    localparam int             HW      = WIDTH / 2;
    localparam logic [SHW:0]   AW_FULL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0]   AW_HALF = (SHW+1)'(WIDTH / 2);
    localparam logic [SHW:0]   CNT_ONE = (SHW+1)'(1);

    logic [1:0]       state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]       sr_q, sr_d;

    op_e              op_in;
    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flags;
    logic [SHW:0]     n_raw;
    logic [SHW:0]     n_clamp;
    logic [WIDTH-1:0] shifted;
    logic             bit_out;
    logic             msb;
    logic [3:0]       sh_flags;

    assign op_in = op_e'(op);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op    (op_in),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .c_in  (sr_q[FLAG_C]),
        .res   (core_res),
        .flags (core_flags)
    );

    always_comb begin
        n_raw   = {1'b0, b[SHW-1:0]};
        n_clamp = (n_raw > (mode ? AW_FULL : AW_HALF)) ? (mode ? AW_FULL : AW_HALF) : n_raw;
    end

    // One-bit step on the working register; upper half stays zero in half-word mode.
    always_comb begin
        shifted = work_q;
        bit_out = 1'b0;
        msb     = mode_q ? work_q[WIDTH-1] : work_q[HW-1];
        case (op_q)
            OP_SHR: begin
                bit_out = work_q[0];
                shifted = work_q >> 1;
            end
            OP_SHL: begin
                bit_out = msb;
                shifted = mode_q ? {work_q[WIDTH-2:0], 1'b0}
                                 : {{HW{1'b0}}, work_q[HW-2:0], 1'b0};
            end
            OP_ROR: begin
                bit_out = work_q[0];
                shifted = mode_q ? {work_q[0], work_q[WIDTH-1:1]}
                                 : {{HW{1'b0}}, work_q[0], work_q[HW-1:1]};
            end
            OP_ROL: begin
                bit_out = msb;
                shifted = mode_q ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
                                 : {{HW{1'b0}}, work_q[HW-2:0], work_q[HW-1]};
            end
            default: ;
        endcase
        sh_flags         = '0;
        sh_flags[FLAG_S] = mode_q ? shifted[WIDTH-1] : shifted[HW-1];
        sh_flags[FLAG_Z] = (shifted == '0);
        sh_flags[FLAG_C] = bit_out;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        mode_d     = mode_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        sr_d       = sr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift(op_in) && (n_clamp != '0)) begin
                        state_d = ST_SHIFT;
                        cnt_d   = n_clamp;
                        op_d    = op_in;
                        mode_d  = mode;
                        work_d  = core_res;
                    end else begin
                        state_d    = ST_DONE;
                        out_data_d = core_res;
                        sr_d       = core_flags;
                    end
                end
            end
            ST_SHIFT: begin
                cnt_d  = cnt_q - CNT_ONE;
                work_d = shifted;
                if (cnt_q == CNT_ONE) begin
                    state_d    = ST_DONE;
                    out_data_d = shifted;
                    sr_d       = sh_flags;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_NOT;
            mode_q     <= 1'b0;
            work_q     <= '0;
            out_data_q <= '0;
            sr_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            work_q     <= work_d;
            out_data_q <= out_data_d;
            sr_q       <= sr_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign sr        = sr_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results from an arithmetic
// reference model, a negedge monitor pops and compares on each output transfer.
module tb_alu_seq;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   sr;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   hold_bp = 1'b0;
    logic [3:0] model_sr = 4'h0;

    typedef struct {
        logic [19:0] d;
        logic [3:0]  s;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sr        (sr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (!hold_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the active width.
    function automatic void model(input int o, input bit m, input logic [19:0] ai, input logic [19:0] bi,
                                  input logic [3:0] s, output logic [19:0] d, output logic [3:0] so,
                                  output int lat);
        int     aw, n;
        longint mk, half, am, bm, sa, sb, r, fl, fsrc, res_s, ci;
        bit     c, v;
        aw   = m ? 20 : 10;
        mk   = (longint'(1) << aw) - 1;
        half = longint'(1) << (aw - 1);
        am   = longint'(ai) & mk;
        bm   = longint'(bi) & mk;
        sa   = (am >= half) ? am - 2 * half : am;
        sb   = (bm >= half) ? bm - 2 * half : bm;
        ci   = s[0] ? 1 : 0;
        c    = s[0];
        v    = 1'b0;
        lat  = 1;
        r    = am;
        fl   = 0;
        res_s = 0;
        case (o)
            0: r = ~am & mk;
            1: r = am & bm;
            2: r = am | bm;
            3: r = am ^ bm;
            4, 5, 6, 7: begin
                n = int'(bi[4:0]);
                if (n > aw) n = aw;
                if (n > 0) begin
                    lat = n + 1;
                    case (o)
                        4: begin r = am >> n;                                 c = am[n-1];  end
                        5: begin r = (am << n) & mk;                          c = am[aw-n]; end
                        6: begin r = ((am >> n) | (am << (aw - n))) & mk;     c = am[n-1];  end
                        default: begin r = ((am << n) | (am >> (aw - n))) & mk; c = am[aw-n]; end
                    endcase
                end
            end
            8:  begin fl = am + 1;       res_s = sa + 1;       c = (fl > mk); end
            9:  begin fl = am - 1;       res_s = sa - 1;       c = (fl < 0);  end
            10: begin fl = am + bm;      res_s = sa + sb;      c = (fl > mk); end
            11: begin fl = am + bm + ci; res_s = sa + sb + ci; c = (fl > mk); end
            12, 14: begin fl = am - bm;  res_s = sa - sb;      c = (fl < 0);  end
            13: begin fl = am - bm - ci; res_s = sa - sb - ci; c = (fl < 0);  end
            default: ;
        endcase
        if (o >= 8 && o <= 14) begin
            v = (res_s >= half) || (res_s < -half);
            if (o != 14) r = fl & mk;
        end
        fsrc = (o == 14) ? (fl & mk) : r;
        d    = r[19:0];
        so   = {v, fsrc[aw-1], (fsrc == 0), c};
        if (o == 15) so = ai[3:0];
    endfunction

    task automatic issue(input int o, input bit m, input logic [19:0] aa, input logic [19:0] bb,
                         input bit use_c, input logic [19:0] cd, input logic [3:0] cs, input int clat);
        exp_t        e;
        int          w;
        logic [19:0] md;
        logic [3:0]  ms;
        int          ml;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", w);
            return;
        end
        op = 4'(o);
        mode = m;
        a = aa;
        b = bb;
        in_valid = 1'b1;
        model(o, m, aa, bb, model_sr, md, ms, ml);
        if (use_c) begin
            md = cd;
            ms = cs;
            ml = clat;
        end
        e.d   = md;
        e.s   = ms;
        e.lat = ml;
        e.acc = cyc;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        model_sr = ms;
        in_valid = 1'b0;
        op   = 4'($urandom);
        a    = 20'($urandom);
        b    = 20'($urandom);
        mode = 1'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic        held = 1'b0;
    logic [19:0] prev_d;
    logic [3:0]  prev_s;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: data %0h with nothing outstanding", out_data);
                end else begin
                    if (!held) begin
                        chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                    end else begin
                        chk("hold_data", out_data, prev_d);
                        chk("hold_sr", sr, prev_s);
                    end
                    if (out_ready) begin
                        chk("data", out_data, exp_q[0].d);
                        chk("sr", sr, exp_q[0].s);
                        void'(exp_q.pop_front());
                    end
                end
            end
            held   = out_valid && !out_ready;
            prev_d = out_data;
            prev_s = sr;
        end
    end

    int          ro;
    bit          rm;
    logic [19:0] ra, rb;
    logic [19:0] corners [7] = '{20'h00000, 20'hFFFFF, 20'h7FFFF, 20'h80000, 20'h001FF, 20'h00200, 20'h003FF};

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        op = 4'h0;
        mode = 1'b1;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sr", sr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        issue(10, 1, 20'hFFFFF, 20'h00001, 1, 20'h00000, 4'b0011, 1);
        issue(10, 0, 20'hAB3FF, 20'h00001, 1, 20'h00000, 4'b0011, 1);
        issue(11, 1, 20'h00005, 20'h00003, 1, 20'h00009, 4'b0000, 1);
        issue(5,  1, 20'hE0001, 20'd3,     1, 20'h00008, 4'b0001, 4);
        issue(6,  1, 20'h8ABCD, 20'd20,    1, 20'h8ABCD, 4'b0101, 21);
        issue(14, 1, 20'h00003, 20'h00005, 1, 20'h00003, 4'b0101, 1);
        issue(15, 1, 20'h0000A, 20'h00000, 1, 20'h0000A, 4'b1010, 1);
        issue(8,  1, 20'h7FFFF, 20'h0, 0, 0, 0, 0);
        issue(9,  0, 20'h00000, 20'h0, 0, 0, 0, 0);
        issue(13, 1, 20'h80000, 20'h0, 0, 0, 0, 0);
        issue(7,  0, 20'h00201, 20'd31, 0, 0, 0, 0);
        issue(4,  1, 20'h12345, 20'd0, 0, 0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            ro = $urandom_range(0, 15);
            rm = 1'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 6)] : 20'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? 20'($urandom) : 20'($urandom_range(0, 12));
            issue(ro, rm, ra, rb, 0, 0, 0, 0);
        end
        drain();

        // Back-pressure: result held while a different op is offered.
        @(posedge clk);
        #1;
        hold_bp = 1'b1;
        out_ready = 1'b0;
        issue(3, 1, 20'h0F0F0, 20'h00FF0, 0, 0, 0, 0);
        chk("bp_valid_seen", out_valid, 1);
        op = 4'd10;
        a = 20'h11111;
        b = 20'h22222;
        mode = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_no_extra", out_valid, 0);
        chk("bp_queue_empty", exp_q.size(), 0);
        hold_bp = 1'b0;

        // Reset in the middle of a long shift.
        issue(15, 1, 20'h0000F, 20'h0, 0, 0, 0, 0);
        drain();
        issue(5, 1, 20'h00123, 20'd15, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("sr_mid_shift", sr, 4'hF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        model_sr = 4'h0;
        chk("rst_shift_out_valid", out_valid, 0);
        chk("rst_shift_sr", sr, 0);
        chk("rst_shift_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_shift_in_ready", in_ready, 1);
        issue(11, 1, 20'h00001, 20'h00001, 0, 0, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked, multi-cycle ALU that generalises the team's 20-bit combinational op set (logic, shift/rotate, arithmetic, compare) into one registered unit. It has a persistent status register {V,S,Z,C}, a carry chain across operations, and shift/rotate by a variable amount executed one bit per cycle. It sits between the decode stage and the register-file write-back; branch logic reads its flags.

## Interface
- `WIDTH`, 20: datapath width; must be even and ≥ 4.
- `SHW`, $clog2(WIDTH): width of the shift-amount field.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: unit idle and accepting; transfer when `in_valid && in_ready`.
- `op` in 4: opcode (encodings in package).
- `mode` in 1: 1 = full-word, 0 = half-word (low WIDTH/2 bits).
- `a`, `b` in WIDTH: operands; `b[SHW-1:0]` is the shift amount for shift/rotate.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result; transfer when `out_valid && out_ready`.
- `out_data` out WIDTH: result.
- `sr` out 4: status register {V,S,Z,C}.

## Operation
- Opcodes: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 INC, 9 DEC, 10 ADD, 11 ADC, 12 SUB, 13 SBB, 14 CMP, 15 LDSR.
- Active width AW = WIDTH in full-word mode, WIDTH/2 in half-word mode. Operands are truncated to AW, result bits above AW are 0, and flags are computed on AW.
- Z = result==0. S = result[AW-1]. Arithmetic sets C = carry-out (ADD/ADC/INC) or borrow (SUB/SBB/DEC/CMP), and sets V = signed overflow.
- Logic ops clear V and leave C unchanged.
- ADC adds C. SBB subtracts C.
- CMP computes a−b for flags only; `out_data` = a.
- LDSR: `sr <= a[3:0]`; `out_data` = a.
- Shifts and rotates:
  - n = `b[SHW-1:0]`, clamped to AW.
  - One bit moves per SHIFT cycle; C = last bit shifted or rotated out.
  - SHR/SHL fill with 0.
  - n = 0: result = a, C unchanged.
  - V cleared.
- FSM states:
  - IDLE: `in_ready`=1.
    - On accept, a shift/rotate with n≥1 goes to SHIFT with count=n.
    - Otherwise goes to DONE with result and flags computed.
  - SHIFT: one step per cycle, count−1. The edge with count==1 goes to DONE and loads the flags.
  - DONE: `out_valid`=1. On `out_ready` goes to IDLE.
- `sr` updates only on entry to DONE (LDSR included). `sr` is never altered mid-shift.
- `out_data` and `sr` hold stable while `out_valid && !out_ready`.
- `in_valid` is ignored outside IDLE. Operands are captured at acceptance; later changes on `a`, `b`, `op` and `mode` have no effect.

## Timing
- Reset (`rst` high at an edge): state = IDLE, `out_valid`=0, `out_data`=0, `sr`=0, count=0.
  - `in_ready`=0 while `rst` is high.
  - Reset dominates any simultaneous handshake.
  - Reset mid-SHIFT or in DONE discards the operation.
- Latency is counted from the acceptance edge to `out_valid`:
  - Non-shift ops, and shifts with n=0: 1 cycle.
  - Shift or rotate by n≥1: n+1 cycles.
- Throughput: at most one op per 2 cycles. `in_ready` rises the cycle after the output transfer.
- `in_ready` is combinational from state and `rst` only. `out_valid`, `out_data` and `sr` are registered.

## Structure
- Package `alu_pkg`: opcode enum, flag bit indices (V=3, S=2, Z=1, C=0), FSM state enum.
- Sub-module `alu_core`: combinational single-cycle ops (logic, INC/DEC, ADD..CMP, mode masking, flag generation).
- The top level holds the FSM, shift counter, working register and status register.

## Test plan
All scenarios use WIDTH=20.
- ADD, mode=1, a=0xFFFFF, b=0x00001 → `out_data`=0x00000, `sr`={0,0,1,1}, `out_valid` 1 cycle after accept.
- ADD, mode=0, a=0xAB3FF, b=0x00001 → `out_data`=0x00000, C=1, Z=1. Then ADC, mode=1, a=5, b=3 → `out_data`=0x00009, C=0, Z=0.
- SHL, mode=1, a=0xE0001, b=3 → `out_data`=0x00008, C=1; `out_valid` exactly 4 cycles after accept. ROR with b=20 → `out_data`=a.
- CMP, mode=1, a=3, b=5 → `out_data`=0x00003, `sr`={0,1,0,1}. LDSR with a=0x0000A → `sr`=4'b1010.
- Back-pressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `out_valid`, `out_data` and `sr` stable, `in_ready`=0, no new op accepted.
- Reset mid-SHIFT: SHL with b=15, assert `rst` on the 3rd SHIFT cycle → next cycle IDLE, `out_valid`=0, `sr`=0; `in_ready`=1 after `rst` drops.
